// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI data-path blocks.
package spi_pkg;

    localparam int FIFO_WIDTH_DEF = 32'sd32;
    localparam int FIFO_DEPTH_DEF = 32'sd16;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array: one write port, one registered read port.
module fifo_mem_2p
    import spi_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read port: same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy, thresholds, error pulses and flush.
module fifo_sync_param
    import spi_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 32'sd2,
    parameter int AE_LEVEL = 32'sd2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 32'sd1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

    if ((DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if ((AE_LEVEL < 32'sd0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
        $error("fifo_sync_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             dout_valid_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             dout_zero_r;
    logic [PTR_W-1:0] count_s;
    logic             empty_s;
    logic             full_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             mem_wr_s;
    logic             mem_rd_s;
    logic [WIDTH-1:0] mem_rd_data_s;

    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (count_s == {PTR_W{1'b0}});
    assign full_s  = (count_s == DEPTH_C);

    // Acceptance: a read can make room for a write, never the reverse.
    always_comb begin
        rd_ok_s  = 1'b0;
        wr_ok_s  = 1'b0;
        mem_wr_s = 1'b0;
        mem_rd_s = 1'b0;
        if (rd_en && !empty_s) begin
            rd_ok_s = 1'b1;
        end else begin
            rd_ok_s = 1'b0;
        end
        if (wr_en && (!full_s || rd_ok_s)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
        if (clear) begin
            mem_wr_s = 1'b0;
            mem_rd_s = 1'b0;
        end else begin
            mem_wr_s = wr_ok_s;
            mem_rd_s = rd_ok_s;
        end
    end

    // Pointers, read strobe and error pulses; flush overrides any request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else if (clear) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            dout_valid_r <= rd_ok_s;
            overflow_r   <= wr_en & ~wr_ok_s;
            underflow_r  <= rd_en & empty_s;
        end
    end

    // The array has no reset, so dout is forced to zero until the first read lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_zero_r <= 1'b1;
        end else if (mem_rd_s) begin
            dout_zero_r <= 1'b0;
        end else begin
            dout_zero_r <= dout_zero_r;
        end
    end

    fifo_mem_2p #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_s),
        .wr_addr (wr_ptr_r[ADDR_W-1:0]),
        .wr_data (din),
        .rd_en   (mem_rd_s),
        .rd_addr (rd_ptr_r[ADDR_W-1:0]),
        .rd_data (mem_rd_data_s)
    );

    assign dout         = dout_zero_r ? {WIDTH{1'b0}} : mem_rd_data_s;
    assign dout_valid   = dout_valid_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
    assign count        = count_s;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_full  = (count_s >= AF_C);
    assign almost_empty = (count_s <= AE_C);

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO, the next generation of the team's 32x16 FIFO. Adds:
- configurable width and depth;
- use of all DEPTH entries, via an extra pointer wrap bit;
- occupancy count, almost-full/almost-empty thresholds, overflow/underflow error pulses;
- a read-data valid strobe and a synchronous flush.

It sits between SPI shift logic and the bus/register side as the generic TX/RX data buffer.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  in  1  single clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of all contents
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request
dout  out  WIDTH  registered read data
dout_valid  out  1  dout updated this cycle (1-cycle pulse)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  1-cycle pulse: write rejected
underflow  out  1  1-cycle pulse: read rejected

Behaviour:
- Interface: one clock, clk; reset_n asynchronous, active-low.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits wide, ADDR_W = clog2(DEPTH). Address is ptr[ADDR_W-1:0]; the MSB is the wrap bit.
- Count: count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)). full/empty/almost_* are combinational from registered pointers.
- Read acceptance: rd_ok = rd_en & !empty.
- Write acceptance: wr_ok = wr_en & (!full | rd_ok).
  - Write while full is accepted if a read is accepted in the same cycle; count is unchanged.
  - Read while empty is always rejected, even with a simultaneous write. The write is accepted; count becomes 1.
- Write: on wr_ok, mem[wr_ptr addr] <= din and wr_ptr increments at the next edge.
- Read: on rd_ok, at the next edge dout <= mem[rd_ptr addr], rd_ptr increments and dout_valid = 1 for that cycle. Read latency is one cycle.
- dout holds its last value when no read occurs. dout_valid is 0 otherwise.
- Error pulses:
  - overflow = 1 for the cycle after wr_en & !wr_ok.
  - underflow = 1 for the cycle after rd_en & empty.
  - Both are registered and non-sticky.
- Simultaneous wr_ok and rd_ok with count==1: the read returns the old head entry, the new word is stored, count stays 1. No write-to-read bypass.
- Pointer wrap: natural modulo 2^(ADDR_W+1). No special case at address DEPTH-1 -> 0.
- clear, synchronous:
  - At the next edge, both pointers go to 0, and dout_valid, overflow and underflow go to 0.
  - dout retains its value.
  - clear has priority over wr_en/rd_en that cycle: nothing is stored or read, and no error pulses.
- Reset (reset_n low, asynchronous, at any time including mid-burst):
  - Pointers go to 0, dout = 0, dout_valid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - Memory array is not reset; its contents are unobservable until rewritten.
- Elaboration checks: DEPTH must be a power of two, and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. Violation is an elaboration-time error.

Decomposition:
- Shared package spi_pkg: clog2 constant function and a default FIFO width/depth localparam.
- One sub-module fifo_mem_2p: simple dual-port array (WIDTH x DEPTH), one write port and one synchronous read port with read enable, no reset.
- Pointer, flag and error logic live in fifo_sync_param.

Test Plan:
All scenarios use WIDTH=32, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2.
1. Reset then fill: write 16 words 0x1000+i.
   - count reaches 16, full=1 only after the 16th write.
   - almost_full first asserts at count 12; almost_empty deasserts at count 3.
   - 17th write -> overflow pulse, count stays 16.
2. Drain: read 16 times.
   - dout = 0x1000..0x100F in order, each one cycle after rd_en, with dout_valid pulsed.
   - empty=1 after the last read; a further rd_en -> underflow pulse, dout holds 0x100F.
3. Wrap and concurrency:
   - Push 10 and pop 10, repeated 5 times, so pointers cross the wrap bit; data order is preserved throughout.
   - At full, assert wr_en and rd_en together: count stays 16, no overflow, and the new word is read last.
4. Empty plus simultaneous read/write: at count 0, assert wr_en (0xABCD) and rd_en together.
   - underflow pulse, count=1, no dout_valid.
   - Next read returns 0xABCD.
5. Flush: with count=7, assert clear together with wr_en.
   - Next cycle count=0, empty=1, no overflow.
   - dout unchanged.
   - Subsequent write/read returns only the new data.
6. Async reset mid-burst: drop reset_n between clock edges during back-to-back writes.
   - count=0, empty=1, dout=0 immediately, without waiting for a clock edge.
   - After release, the FIFO operates normally from pointer 0.
